// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX path (and the future RX path):
// FSM encoding, frame constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic PARITY_EVEN    = 1'b0;
  localparam logic PARITY_ODD     = 1'b1;

  // Bit that makes the total count of ones even (mode=PARITY_EVEN) or odd.
  function automatic logic parity_of(input logic [UART_DATA_BITS-1:0] data,
                                     input logic                      mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick pulses for one cycle every div+1 cycles after clear.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // Decoded from the count only, so tick never depends on clear.
  assign tick = (cnt == div);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink driving a UART TXD line (8 data bits, LSB first,
// optional parity, 1 or 2 stop bits) with gap-free back-to-back frames.
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int   DIV_WIDTH  = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic                 txd,
  output logic                 busy
);

  uart_state_e          state, state_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic [7:0]           shift, shift_next;
  logic                 txd_next, busy_next;
  logic                 capture;
  logic                 ready_en;
  logic                 tick;
  logic                 last_stop;
  logic                 handshake;

  // Frame configuration frozen at the handshake.
  logic [DIV_WIDTH-1:0] div_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == ST_IDLE),
    .div  (div_q),
    .tick (tick)
  );

  assign last_stop = (bit_cnt == 3'(stop2_q));
  assign s_ready   = ready_en &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && tick && last_stop));
  assign handshake = s_valid && s_ready;

  // NOTE: ready_en holds s_ready low through reset and for the first edge
  // after release, without routing rst_n into combinational logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    txd_next     = txd;
    busy_next    = busy;
    capture      = 1'b0;

    case (state)
      ST_IDLE: begin
        txd_next  = IDLE_LEVEL;
        busy_next = 1'b0;
      end
      ST_START: begin
        if (tick) begin
          state_next   = ST_DATA;
          txd_next     = shift[0];
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
            bit_cnt_next = '0;
            if (par_en_q) begin
              state_next = ST_PARITY;
              txd_next   = par_bit_q;
            end else begin
              state_next = ST_STOP;
              txd_next   = IDLE_LEVEL;
            end
          end else begin
            shift_next   = shift >> 1;
            txd_next     = shift[1];
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next   = ST_STOP;
          txd_next     = IDLE_LEVEL;
          bit_cnt_next = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (last_stop) begin
            state_next = ST_IDLE;
            txd_next   = IDLE_LEVEL;
            busy_next  = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A handshake in the last stop cycle overrides the return to IDLE.
    if (handshake) begin
      capture      = 1'b1;
      state_next   = ST_START;
      txd_next     = ~IDLE_LEVEL;
      busy_next    = 1'b1;
      shift_next   = s_data;
      bit_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      txd       <= IDLE_LEVEL;
      busy      <= 1'b0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      txd     <= txd_next;
      busy    <= busy_next;
      if (capture) begin
        div_q     <= baud_div;
        par_en_q  <= parity_en;
        par_bit_q <= parity_of(s_data, parity_odd ? PARITY_ODD : PARITY_EVEN);
        stop2_q   <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Self-checking bench for axis_uart_tx: directed frames plus randomized
// frames checked cycle by cycle against a bit-position model of the line.
module tb_axis_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        txd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  axis_uart_tx #(
    .DIV_WIDTH (16),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
    .txd       (txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level in bit slot idx of a frame: start, d[0..7], parity or stop, stop.
  function automatic logic exp_txd(input logic [7:0] d, input logic pe, input logic po,
                                   input int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) begin
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return ((ones % 2) == 1) ^ po;
    end
    return 1'b1;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'(1));
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_ready", 32'(s_ready), 32'(1));
    end
  endtask

  // Offers one byte, waits for the handshake, then checks every cycle of the
  // frame. Returns at the frame's last negedge so a following call chains
  // gap-free. garble drives junk (s_valid, data, config) during the frame.
  task automatic send(input logic [7:0] d, input int div, input logic pe, input logic po,
                      input logic s2, input bit garble, input int abort_at,
                      output int hs_cyc);
    int w;
    int bp;
    int len;
    hs_cyc     = -1;
    s_valid    = 1'b1;
    s_data     = d;
    baud_div   = 16'(div);
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    w = 0;
    while (s_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (s_ready !== 1'b1) begin
      check("hs_timeout", 32'(s_ready), 32'(1));
      s_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    s_data = 8'($urandom);
    if (garble) begin
      baud_div   = 16'($urandom_range(1, 6));
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2      = 1'($urandom);
    end else begin
      s_valid = 1'b0;
    end
    bp  = div + 1;
    len = (10 + int'(pe) + int'(s2)) * bp;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check("txd", 32'(txd), 32'(exp_txd(d, pe, po, k / bp)));
      check("busy", 32'(busy), 32'(1));
      check("s_ready", 32'(s_ready), 32'(k == len - 1));
      if (k == abort_at) return;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int h0, h1, h2, h3;
    logic [7:0] d;
    int div;
    logic pe, po, s2;
    bit garble;

    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    baud_div   = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;

    // Reset state, held across several edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ready", 32'(s_ready), 32'(0));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(s_ready), 32'(1));
    idle_check(2);

    // Basic 8N1.
    send(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1, h0);
    idle_check(1);

    // Even then odd parity, two stop bits.
    send(8'hA7, 1, 1'b1, 1'b0, 1'b1, 1'b0, -1, h0);
    idle_check(1);
    send(8'hA7, 1, 1'b1, 1'b1, 1'b1, 1'b0, -1, h0);
    idle_check(1);

    // Back-to-back frames with no idle gap.
    send(8'h01, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1, h1);
    send(8'h02, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1, h2);
    send(8'h03, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1, h3);
    check("b2b_gap12", 32'(h2 - h1), 32'(40));
    check("b2b_gap23", 32'(h3 - h2), 32'(40));
    idle_check(1);

    // Backpressure with junk data and config mid-frame.
    send(8'($urandom), 3, 1'b0, 1'b0, 1'b0, 1'b1, -1, h0);
    idle_check(1);

    // Reset during data bit 3.
    send(8'h3C, 3, 1'b0, 1'b0, 1'b0, 1'b0, 17, h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_txd", 32'(txd), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ready", 32'(s_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rel_ready", 32'(s_ready), 32'(1));
    @(negedge clk);
    send(8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1, h0);
    idle_check(1);

    // Randomized frames, sometimes chained, sometimes with idle gaps.
    for (int i = 0; i < 16; i++) begin
      d      = 8'($urandom);
      div    = int'($urandom_range(1, 4));
      pe     = 1'($urandom);
      po     = 1'($urandom);
      s2     = 1'($urandom);
      garble = 1'($urandom);
      send(d, div, pe, po, s2, garble, -1, h0);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 5)));
    end

    // Long idle stretch.
    idle_check(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
